prog_timer: RTL and testbench
=============================

// Module: prog_timer
// PURPOSE
//  Parametrised down-counting timer. Next generation of the 16-bit load/count timer.
//  Adds over it: configurable width, programmable prescaler, one-shot/auto-reload mode,
//  terminal-count pulse and status flags.
//  Sits beside the datapath as a reusable interval/timeout source; tc drives interrupt or sequencing logic.
// PARAMETERS
//  WIDTH       16  count, load and reload register width
//  PRESCALE_W  8   prescaler counter and psc input width
// PORTS
//  clk      in   1           clock; all logic rising-edge
//  sclr_n   in   1           reset; synchronous, active-low
//  din      in   WIDTH       load value, captured when ld=1
//  ld       in   1           load din into count and reload registers, start timer
//  cnt_en   in   1           count enable; 0 freezes count and prescaler
//  mode     in   1           0 = one-shot, 1 = auto-reload
//  psc      in   PRESCALE_W  prescale; one count tick per psc+1 enabled cycles
//  dout     out  WIDTH       current count
//  tc       out  1           terminal-count pulse, one cycle wide
//  running  out  1           1 while in RUN
//  done     out  1           sticky one-shot expiry flag
// BEHAVIOUR
//  - Reset, when sclr_n=0 at a rising edge:
//    - dout, reload, prescaler, tc, running and done all go to 0; state goes to IDLE.
//    - Reset overrides ld and every other input, including in mid-count.
//  - State machine: IDLE, RUN, DONE. running = (state==RUN).
//  - Priority order: reset, then ld, then tick.
//  - ld:
//    - Next edge: dout<=din, reload<=din, prescaler<=0, done<=0, tc<=0.
//    - State goes to RUN if din!=0, else IDLE.
//    - Accepted in any state. Latency is 1 cycle.
//    - If ld coincides with a tick, ld wins and tc is not asserted.
//  - Tick:
//    - Occurs when state==RUN and cnt_en=1 and prescaler>=psc; the prescaler then goes to 0.
//    - If state==RUN and cnt_en=1 and prescaler<psc, the prescaler increments instead.
//    - The >= compare means a psc lowered mid-count takes effect on the next enabled cycle.
//  - On a tick, dout!=1: dout<=dout-1; tc<=0.
//  - On a tick, dout==1, mode=1: dout<=reload; tc<=1; state stays RUN.
//    - Period is reload*(psc+1) enabled cycles.
//  - On a tick, dout==1, mode=0: dout<=0; tc<=1; done<=1; state goes to DONE.
//  - tc is registered and asserts on the same edge dout takes its post-expiry value.
//    - It is high for exactly one cycle; it is never high two cycles in a row unless reload==1 and psc==0.
//  - cnt_en=0 in RUN: dout, prescaler and state hold; tc=0.
//  - IDLE: dout and prescaler hold, tc=0, no counting.
//  - DONE: dout holds 0, done holds 1, tc=0. Only ld or reset exits DONE.
//  - mode is sampled at expiry only; changing it mid-count is legal.
//  - No wrap-around: dout never decrements past 0; 0 is reached only through a one-shot expiry.
//  - Arithmetic is unsigned, WIDTH bits. din=2^WIDTH-1 is legal.
// TESTING
//  1. Reset: hold sclr_n=0 for 2 cycles with ld=1, din=5.
//     -> dout=0, tc=0, running=0, done=0; stays IDLE after release while ld=0.
//  2. One-shot: mode=0, psc=0, cnt_en=1, pulse ld with din=3.
//     -> dout 3,2,1,0 on consecutive edges; tc high only with dout=0.
//     -> done=1, running=0; dout holds 0 for 10 cycles.
//  3. Auto-reload: mode=1, psc=0, din=4.
//     -> dout 4,3,2,1,4,3,...; exactly 3 tc pulses in 12 cycles, each 4 cycles apart.
//  4. Prescale: psc=2, mode=0, din=2.
//     -> dout changes every 3 enabled cycles; tc 6 cycles after the load edge.
//  5. Freeze and edge loads:
//     - Drop cnt_en for 5 cycles at dout=5 -> dout and prescaler frozen; countdown resumes exactly.
//     - ld with din=0 -> IDLE, running=0, no tc.
//  6. Load collision: assert ld with din=7 on the cycle dout=1 would tick.
//     -> dout=7, tc=0, running=1; with WIDTH=16, din=16'hFFFF decrements to 16'hFFFE.

Source files
------------

// File: rtl/prog_timer.sv
// ============================================================================
// Module      : prog_timer
// Description : Parametrised down-counting timer with prescaler, one-shot or
//               auto-reload mode, terminal-count pulse and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_timer #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  sclr_n,
  input  logic [WIDTH-1:0]      din,
  input  logic                  ld,
  input  logic                  cnt_en,
  input  logic                  mode,
  input  logic [PRESCALE_W-1:0] psc,
  output logic [WIDTH-1:0]      dout,
  output logic                  tc,
  output logic                  running,
  output logic                  done
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [WIDTH-1:0]      c_cnt_zero = '0;
  localparam logic [WIDTH-1:0]      c_cnt_one  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] c_psc_one  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [WIDTH-1:0]      r_count;
  logic [WIDTH-1:0]      r_reload;
  logic [PRESCALE_W-1:0] r_psc_cnt;
  logic                  r_tc;
  logic                  r_done;
  logic                  w_enabled;
  logic                  w_tick;
  logic                  w_expire;

  // A psc lowered below the running prescaler fires on the next enabled cycle.
  assign w_enabled = (r_state == c_st_run) && cnt_en;
  assign w_tick    = w_enabled && (r_psc_cnt >= psc);
  assign w_expire  = w_tick && (r_count == c_cnt_one);

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (ld) begin
      w_state_nxt = (din != c_cnt_zero) ? c_st_run : c_st_idle;
    end else if (w_expire && !mode) begin
      w_state_nxt = c_st_done;
    end
  end

  always_comb begin
    running = (r_state == c_st_run);
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      r_count   <= '0;
      r_reload  <= '0;
      r_psc_cnt <= '0;
      r_tc      <= 1'b0;
      r_done    <= 1'b0;
    end else if (ld) begin
      r_count   <= din;
      r_reload  <= din;
      r_psc_cnt <= '0;
      r_tc      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (w_tick) begin
        r_psc_cnt <= '0;
        if (w_expire) begin
          r_tc <= 1'b1;
          if (mode) begin
            r_count <= r_reload;
          end else begin
            r_count <= '0;
            r_done  <= 1'b1;
          end
        end else begin
          r_count <= r_count - c_cnt_one;
        end
      end else if (w_enabled) begin
        r_psc_cnt <= r_psc_cnt + c_psc_one;
      end
    end
  end

  assign dout = r_count;
  assign tc   = r_tc;
  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_prog_timer.sv
// ============================================================================
// Module      : tb_prog_timer
// Description : Directed self-checking bench for prog_timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_timer;

  localparam int WIDTH      = 16;
  localparam int PRESCALE_W = 8;

  logic                  clk;
  logic                  sclr_n;
  logic [WIDTH-1:0]      din;
  logic                  ld;
  logic                  cnt_en;
  logic                  mode;
  logic [PRESCALE_W-1:0] psc;
  logic [WIDTH-1:0]      dout;
  logic                  tc;
  logic                  running;
  logic                  done;

  int n_vec;
  int n_err;
  int n_tc;

  prog_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk     (clk),
    .sclr_n  (sclr_n),
    .din     (din),
    .ld      (ld),
    .cnt_en  (cnt_en),
    .mode    (mode),
    .psc     (psc),
    .dout    (dout),
    .tc      (tc),
    .running (running),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle before sampling or changing inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    ld  = 1'b1;
    din = v;
    step();
    ld  = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_tc = 0;
    sclr_n = 1'b0; ld = 1'b1; din = 16'd5; cnt_en = 1'b1; mode = 1'b0; psc = '0;

    // Reset dominates a concurrent load
    step(); step();
    check("rst_dout", dout, 0);
    check("rst_tc", tc, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    sclr_n = 1'b1; ld = 1'b0;
    step(); step();
    check("idle_dout", dout, 0);
    check("idle_running", running, 0);

    // One-shot countdown 3,2,1,0
    mode = 1'b0; psc = '0;
    load(16'd3);
    check("os_dout0", dout, 3);
    check("os_run", running, 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("os_dout", dout, 3 - i);
      check("os_tc", tc, (i == 3) ? 1 : 0);
    end
    check("os_done", done, 1);
    check("os_running", running, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("os_hold_dout", dout, 0);
      check("os_hold_tc", tc, 0);
      check("os_hold_done", done, 1);
    end

    // Auto-reload, period 4
    mode = 1'b1;
    load(16'd4);
    check("ar_dout0", dout, 4);
    check("ar_done_clr", done, 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      check("ar_dout", dout, (i % 4 == 0) ? 4 : 4 - (i % 4));
      check("ar_tc", tc, (i % 4 == 0) ? 1 : 0);
      if (tc) n_tc++;
    end
    check("ar_tc_count", n_tc, 3);
    check("ar_running", running, 1);

    // reload==1, psc==0: tc every cycle
    load(16'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ar1_dout", dout, 1);
      check("ar1_tc", tc, 1);
    end

    // Prescale by 3
    mode = 1'b0; psc = 8'd2;
    load(16'd2);
    for (int i = 1; i <= 6; i++) begin
      step();
      check("psc_dout", dout, (i < 3) ? 2 : (i < 6) ? 1 : 0);
      check("psc_tc", tc, (i == 6) ? 1 : 0);
    end
    check("psc_done", done, 1);

    // Freeze with prescaler mid-way; resume must tick on the first enabled edge
    psc = 8'd1;
    load(16'd6);
    step(); step(); step();
    check("frz_pre", dout, 5);
    cnt_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("frz_dout", dout, 5);
      check("frz_tc", tc, 0);
      check("frz_run", running, 1);
    end
    cnt_en = 1'b1;
    step(); check("frz_res1", dout, 4);
    step(); check("frz_res2", dout, 4);
    step(); check("frz_res3", dout, 3);

    // Load of zero goes IDLE
    load(16'd0);
    check("ld0_dout", dout, 0);
    check("ld0_running", running, 0);
    check("ld0_tc", tc, 0);
    step();
    check("ld0_hold_dout", dout, 0);
    check("ld0_hold_tc", tc, 0);
    check("ld0_done", done, 0);

    // Load collides with expiring tick
    psc = '0; mode = 1'b0;
    load(16'd2);
    step();
    check("col_pre", dout, 1);
    load(16'd7);
    check("col_dout", dout, 7);
    check("col_tc", tc, 0);
    check("col_run", running, 1);
    check("col_done", done, 0);
    load(16'hFFFF);
    check("max_dout", dout, 16'hFFFF);
    step();
    check("max_dec", dout, 16'hFFFE);

    // Reset mid-count
    sclr_n = 1'b0; ld = 1'b1; din = 16'd9;
    step();
    sclr_n = 1'b1; ld = 1'b0;
    check("mrst_dout", dout, 0);
    check("mrst_running", running, 0);
    step();
    check("mrst_hold", dout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
